// File: rtl/rom_streamer_pkg.sv
// rom_streamer_pkg
//   Shared types and default widths for rom_streamer.
//   - state_t        : burst FSM states (IDLE, RUN, DRAIN)
//   - DEFAULT_ADDR_W : default ROM address width
//   - DEFAULT_DATA_W : default ROM data width
package rom_streamer_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rom_streamer.sv
// rom_streamer
//   Streams a burst of words out of an external combinational ROM through a
//   valid/ready output interface.
//
//   Ports:
//     clk         rising-edge clock
//     rst         asynchronous active-low reset
//     start       burst request (sampled only in IDLE)
//     start_addr  first ROM address of the burst
//     len         burst length, 0 means 2**ADDR_W words
//     busy        high whenever the FSM is not IDLE
//     rom_addr    address to the ROM (registered address counter)
//     rom_data    ROM read data, same cycle as rom_addr
//     out_data    streamed word
//     out_valid   out_data holds a word
//     out_ready   consumer accepts the word
//     done        one-cycle pulse after the final word is accepted
//     chksum      running sum of transferred words mod 2**DATA_W
//                 (only when ROM_STREAMER_CHECKSUM_EN is defined)
//
//   Build option: define ROM_STREAMER_CHECKSUM_EN to add the chksum port.
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
`ifdef ROM_STREAMER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  // One extra bit so a full 2**ADDR_W burst can be counted down.
  logic [ADDR_W:0]   rem_q,   rem_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              done_q,  done_d;
  logic              xfer;

  assign xfer = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          rem_d   = (len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len};
          state_d = RUN;
        end
      end
      RUN: begin
        // Capture when the output register is empty or being emptied this
        // cycle, so a transferred word is replaced without a bubble.
        if (!valid_q || out_ready) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W + 1)'(1);
          if (rem_q == (ADDR_W + 1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign rom_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign done      = done_q;

`ifdef ROM_STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Clear and accumulate cannot coincide: out_valid is always low in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      sum_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign chksum = sum_q;
`endif

endmodule

// File: doc/rom_streamer.md
ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, ROM address width; DATA_W, default 8, ROM data width.
REQ-002 Ports SHALL be, in order:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  burst request, sampled only in IDLE.
- start_addr  input  ADDR_W  first ROM address of the burst.
- len  input  ADDR_W  burst length; 0 encodes 2**ADDR_W words.
- busy  output  1  high in every state other than IDLE.
- rom_addr  output  ADDR_W  address driven to the combinational ROM.
- rom_data  input  DATA_W  ROM read data, valid in the same cycle as rom_addr.
- out_data  output  DATA_W  streamed word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word.
- done  output  1  one-cycle pulse at burst completion.
REQ-003 Clocking SHALL be one clock, clk; the reset, rst, SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN, DRAIN.
REQ-005 IDLE with start=1 SHALL load addr_q=start_addr and rem_q=len (0 maps to 2**ADDR_W), then enter RUN next cycle.
REQ-006 rom_addr SHALL equal addr_q at all times; it SHALL NOT be driven combinationally from start_addr.
REQ-007 A capture in RUN SHALL occur when !out_valid || out_ready, taking out_data<=rom_data, out_valid<=1, addr_q<=addr_q+1, rem_q<=rem_q-1.
REQ-008 Sustained out_ready=1 SHALL give one word per cycle; the first word SHALL appear in out_valid 2 cycles after start.
REQ-009 addr_q SHALL wrap from 2**ADDR_W-1 to 0 with no error.
REQ-010 When the capture of the last word occurs (rem_q==1), the FSM SHALL enter DRAIN.
REQ-011 In DRAIN, out_valid&&out_ready SHALL clear out_valid, pulse done for exactly one cycle, and return the FSM to IDLE.
REQ-012 While out_valid=1 and out_ready=0, out_data, out_valid, addr_q and rem_q SHALL hold stable.
REQ-013 A word transferred in the same cycle as a new capture SHALL be replaced with no bubble.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 start asserted in the IDLE cycle directly after done SHALL be accepted.
REQ-016 A len=0 burst SHALL stream 256 words (ADDR_W=8) and end at start_addr-1 mod 256.

Reset
REQ-017 rst low SHALL immediately force: IDLE, addr_q=0, rem_q=0, out_valid=0, out_data=0, done=0, busy=0.
REQ-018 Reset asserted mid-burst SHALL abort the burst with no done pulse; the first post-reset burst SHALL behave as if from power-up.

Configuration
REQ-019 Macro ROM_STREAMER_CHECKSUM_EN defined SHALL add output chksum (DATA_W). The checksum SHALL:
- clear on start acceptance;
- add each transferred word modulo 2**DATA_W (transfer = out_valid&&out_ready);
- be reset to 0;
- be stable and final in the done cycle.
REQ-020 Without ROM_STREAMER_CHECKSUM_EN, neither the chksum port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-021 Package rom_streamer_pkg SHALL hold:
- the state enum (IDLE, RUN, DRAIN);
- the default ADDR_W and DATA_W constants.
REQ-022 rom_streamer SHALL be a single module with no sub-module; the ROM is instantiated by the enclosing design, not inside this block.

Verification
REQ-023 The bench SHALL attach the team's 8-bit ROM: identity map, except that addresses 24+32k return addr-8.
REQ-024 The bench SHALL cover these directed scenarios:
- start_addr=20, len=6, out_ready=1 -> words 20,21,22,23,16,25 on consecutive cycles; done 1 cycle after the last transfer; chksum=127 when ROM_STREAMER_CHECKSUM_EN is defined.
- start_addr=254, len=4 -> words 254,255,0,1 (wrap-around).
- start_addr=0, len=3, out_ready low for 3 cycles after the first word -> word 0 held stable; the sequence then resumes 1,2 with no loss or duplication.
- start_addr=0, len=0 -> exactly 256 words; word 56 reads 48; one done pulse.
- rst low at the 3rd word of a len=10 burst -> all outputs 0 immediately, no done; a following len=2 burst from 100 yields 100,101.
- start held high for the entire burst plus 1 cycle -> the burst runs once; a second burst starts in the cycle after done.
